// File: rtl/alu_sweep_gen_if.sv
// ALU vector bus between the sweep generator and the ALU under test.
// Handshake: the master raises vld with a stable vector (op, src_data,
// dest_data, ext, misc); a vector is accepted on any rising edge where
// vld && rdy, and res is sampled on that same edge. While vld && !rdy the
// master holds every vector field unchanged. The slave may hold rdy high
// at all times; back-to-back accepts are allowed.
interface alu_sweep_gen_if #(
  parameter int DATA_SIZE = 5,
  parameter int OP_SIZE   = 3,
  parameter int RES_SIZE  = 16
);
  logic [OP_SIZE-1:0]   op;
  logic [DATA_SIZE-1:0] src_data;
  logic [DATA_SIZE-1:0] dest_data;
  logic                 ext;
  logic                 misc;
  logic                 vld;
  logic                 rdy;
  logic [RES_SIZE-1:0]  res;

  // Generator side
  modport master (
    output op, src_data, dest_data, ext, misc, vld,
    input  rdy, res
  );

  // ALU / consumer side
  modport slave (
    input  op, src_data, dest_data, ext, misc, vld,
    output rdy, res
  );
endinterface

// File: rtl/alu_sweep_gen.sv
// ALU exhaustive sweep generator: walks op 0..OP_LAST, dest_data and
// src_data over their full range (src innermost), presents each vector over
// a valid/ready bus, and folds every accepted result into a rotate-xor
// signature while counting accepted vectors.
// Optional feature macro: ALU_SWEEP_EXT_EN -- when defined, ext is swept as
// the outermost dimension (a full pass with ext=0, then one with ext=1).
// When undefined, ext is tied to 0 and a single pass occurs.
module alu_sweep_gen #(
  parameter int DATA_SIZE = 5,
  parameter int OP_SIZE   = 3,
  parameter int RES_SIZE  = 16,
  parameter int OP_LAST   = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          misc_cfg,
  alu_sweep_gen_if.master               vec,
  output logic                          busy,
  output logic                          done,
  output logic [OP_SIZE+2*DATA_SIZE:0]  count,
  output logic [RES_SIZE-1:0]           signature,
  output logic [1:0]                    dbg_state_o
);

  localparam int CNT_W = OP_SIZE + 2 * DATA_SIZE + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [OP_SIZE-1:0]   op_q, op_d;
  logic [DATA_SIZE-1:0] src_q, src_d;
  logic [DATA_SIZE-1:0] dest_q, dest_d;
  logic                 ext_q, ext_d;
  logic                 misc_q, misc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RES_SIZE-1:0]  sig_q, sig_d;

  logic src_max;
  logic dest_max;
  logic op_last;
  logic last_vec;
  logic accept;

  // Position flags of the current vector within the sweep.
  always_comb begin
    src_max  = (src_q == {DATA_SIZE{1'b1}});
    dest_max = (dest_q == {DATA_SIZE{1'b1}});
    op_last  = (op_q == OP_SIZE'(OP_LAST));
`ifdef ALU_SWEEP_EXT_EN
    last_vec = src_max && dest_max && op_last && ext_q;
`else
    last_vec = src_max && dest_max && op_last;
`endif
    accept   = (state_q == ST_RUN) && vec.rdy;
  end

  // Next-state and datapath update; every _d defaults to hold.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dest_d  = dest_q;
    ext_d   = ext_q;
    misc_d  = misc_q;
    cnt_d   = cnt_q;
    sig_d   = sig_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        // A new sweep starts from (0,0,0) with cleared statistics.
        if (start) begin
          state_d = ST_RUN;
          op_d    = '0;
          src_d   = '0;
          dest_d  = '0;
          ext_d   = 1'b0;
          misc_d  = misc_cfg;
          cnt_d   = '0;
          sig_d   = '0;
        end
      end

      ST_RUN: begin
        // start is ignored here; only an accept moves the sweep on.
        if (accept) begin
          sig_d = {sig_q[RES_SIZE-2:0], sig_q[RES_SIZE-1]} ^ vec.res;
          cnt_d = cnt_q + CNT_W'(1);
          if (last_vec) begin
            state_d = ST_DONE;
          end else begin
            src_d = src_q + DATA_SIZE'(1);
            if (src_max) begin
              dest_d = dest_q + DATA_SIZE'(1);
              if (dest_max) begin
                if (op_last) begin
                  // Only reachable with the ext pass enabled: begin ext=1.
                  op_d  = '0;
`ifdef ALU_SWEEP_EXT_EN
                  ext_d = 1'b1;
`else
                  ext_d = 1'b0;
`endif
                end else begin
                  op_d = op_q + OP_SIZE'(1);
                end
              end
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      src_q   <= '0;
      dest_q  <= '0;
      ext_q   <= 1'b0;
      misc_q  <= 1'b0;
      cnt_q   <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dest_q  <= dest_d;
      ext_q   <= ext_d;
      misc_q  <= misc_d;
      cnt_q   <= cnt_d;
      sig_q   <= sig_d;
    end
  end

  // Outputs come straight from registers, so the vector bus is glitch-free.
  assign vec.op        = op_q;
  assign vec.src_data  = src_q;
  assign vec.dest_data = dest_q;
  assign vec.ext       = ext_q;
  assign vec.misc      = misc_q;
  assign vec.vld       = (state_q == ST_RUN);
  assign busy          = (state_q == ST_RUN);
  assign done          = (state_q == ST_DONE);
  assign count         = cnt_q;
  assign signature     = sig_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_alu_sweep_gen.sv
// Directed bench for alu_sweep_gen in a small configuration
// (DATA_SIZE=2, OP_LAST=1): full-sweep ordering, signature values,
// back-pressure, mid-sweep reset and start handling.
module tb_alu_sweep_gen;

  localparam int DS = 2;
  localparam int OS = 3;
  localparam int RS = 16;
  localparam int OL = 1;
  localparam int CW = OS + 2 * DS + 1;
`ifdef ALU_SWEEP_EXT_EN
  localparam int TOTAL = 64;
`else
  localparam int TOTAL = 32;
`endif

  // Clock / reset block
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic misc_cfg;
  logic busy;
  logic done;
  logic [CW-1:0] count;
  logic [RS-1:0] signature;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  alu_sweep_gen_if #(.DATA_SIZE(DS), .OP_SIZE(OS), .RES_SIZE(RS)) vec_if ();

  alu_sweep_gen #(
    .DATA_SIZE(DS), .OP_SIZE(OS), .RES_SIZE(RS), .OP_LAST(OL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .misc_cfg   (misc_cfg),
    .vec        (vec_if.master),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .signature  (signature),
    .dbg_state_o(dbg_state)
  );

  // Scoreboard counters
  int checks   = 0;
  int failures = 0;
  logic [RS-1:0] sig_model;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Expected vector k packed as {ext, op, dest, src}
  function automatic logic [7:0] exp_vec(input int k);
    logic [7:0] v;
    logic [31:0] kk;
    kk = k;
    v[1:0] = kk[1:0];
    v[3:2] = kk[3:2];
    v[6:4] = {2'b00, kk[4]};
`ifdef ALU_SWEEP_EXT_EN
    v[7]   = kk[5];
`else
    v[7]   = 1'b0;
`endif
    return v;
  endfunction

  function automatic logic [7:0] got_vec();
    return {vec_if.ext, vec_if.op, vec_if.dest_data, vec_if.src_data};
  endfunction

  // Driver tasks: advance one cycle and land 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Watchdog so the run always terminates
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    misc_cfg = 1'b0;
    vec_if.rdy = 1'b1;
    vec_if.res = '0;
    step();
    step();

    // Reset state
    check_eq("rst_vld", 32'(vec_if.vld), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_sig", 32'(signature), 0);
    check_eq("rst_vec", 32'(got_vec()), 0);
    check_eq("rst_misc", 32'(vec_if.misc), 0);
    check_eq("rst_state", 32'(dbg_state), 0);
    rst = 1'b0;
    step();

    // Full sweep, res=0, rdy=1, misc latched at start
    misc_cfg = 1'b1;
    pulse_start();
    misc_cfg = 1'b0;
    check_eq("a_count0", 32'(count), 0);
    check_eq("a_busy", 32'(busy), 1);
    for (int k = 0; k < TOTAL; k++) begin
      check_eq($sformatf("a_vec%0d", k), 32'(got_vec()), 32'(exp_vec(k)));
      check_eq($sformatf("a_vld%0d", k), 32'(vec_if.vld), 1);
      step();
    end
    check_eq("a_vld_end", 32'(vec_if.vld), 0);
    check_eq("a_done", 32'(done), 1);
    check_eq("a_busy_end", 32'(busy), 0);
    check_eq("a_count", 32'(count), TOTAL);
    check_eq("a_sig", 32'(signature), 0);
    check_eq("a_misc", 32'(vec_if.misc), 1);
    step();
    check_eq("a_done_hold", 32'(done), 1);
    check_eq("a_count_hold", 32'(count), TOTAL);

    // Restart from DONE with res=1; start at count 5 must be ignored
    vec_if.res = 16'h0001;
    pulse_start();
    check_eq("b_count0", 32'(count), 0);
    check_eq("b_sig0", 32'(signature), 0);
    sig_model = '0;
    for (int k = 0; k < TOTAL; k++) begin
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
      check_eq($sformatf("b_vec%0d", k), 32'(got_vec()), 32'(exp_vec(k)));
      step();
      sig_model = {sig_model[RS-2:0], sig_model[RS-1]} ^ 16'h0001;
      if (k == 0) check_eq("b_sig1", 32'(signature), 32'h0001);
      if (k == 1) check_eq("b_sig2", 32'(signature), 32'h0003);
      if (k == 2) check_eq("b_sig3", 32'(signature), 32'h0007);
      if (k == 15) check_eq("b_sig16", 32'(signature), 32'hFFFF);
    end
    check_eq("b_done", 32'(done), 1);
    check_eq("b_count", 32'(count), TOTAL);
    check_eq("b_sig_final", 32'(signature), 32'(sig_model));

    // Back-pressure at vector (0,2,1), then reset at count 10
    pulse_start();
    for (int k = 0; k < 9; k++) step();
    check_eq("c_vec9", 32'(got_vec()), 32'(exp_vec(9)));
    vec_if.rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq($sformatf("c_stall_vec%0d", i), 32'(got_vec()), 32'(exp_vec(9)));
      check_eq($sformatf("c_stall_cnt%0d", i), 32'(count), 9);
      check_eq($sformatf("c_stall_vld%0d", i), 32'(vec_if.vld), 1);
    end
    vec_if.rdy = 1'b1;
    step();
    check_eq("c_vec10", 32'(got_vec()), 32'(exp_vec(10)));
    check_eq("c_count10", 32'(count), 10);
    check_eq("c_sig10", 32'(signature), 32'h03FF);

    rst = 1'b1;
    start = 1'b1;
    step();
    check_eq("d_vld", 32'(vec_if.vld), 0);
    check_eq("d_busy", 32'(busy), 0);
    check_eq("d_done", 32'(done), 0);
    check_eq("d_count", 32'(count), 0);
    check_eq("d_sig", 32'(signature), 0);
    check_eq("d_vec", 32'(got_vec()), 0);
    check_eq("d_state", 32'(dbg_state), 0);
    rst = 1'b0;
    start = 1'b0;
    step();
    check_eq("d_idle_vld", 32'(vec_if.vld), 0);
    pulse_start();
    check_eq("d_restart_vec", 32'(got_vec()), 32'(exp_vec(0)));
    check_eq("d_restart_vld", 32'(vec_if.vld), 1);
    step();
    check_eq("d_restart_vec1", 32'(got_vec()), 32'(exp_vec(1)));
    check_eq("d_restart_cnt1", 32'(count), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sweep_gen.md
ALU_SWEEP_GEN -- requirements
Module: alu_sweep_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port rst.
REQ-002 Parameter DATA_SIZE SHALL default to 5 and set the src_data/dest_data width.
REQ-003 Parameter OP_SIZE SHALL default to 3 and set the op width.
REQ-004 Parameter RES_SIZE SHALL default to 16 and set the res/signature width.
REQ-005 Parameter OP_LAST SHALL default to 6 and be the last op code swept (sweep covers 0..OP_LAST).
REQ-006 Port clk, input, 1: rising-edge clock.
REQ-007 Port rst, input, 1: synchronous active-high reset.
REQ-008 Port start, input, 1: sweep request, sampled each cycle.
REQ-009 Port misc_cfg, input, 1: value driven on misc for the whole sweep, latched at start.
REQ-010 Ports op [OP_SIZE], src_data [DATA_SIZE], dest_data [DATA_SIZE], ext [1], misc [1] SHALL be registered outputs carrying the current ALU vector.
REQ-011 Ports vld (output, 1) and rdy (input, 1) SHALL be the vector handshake.
REQ-012 Port res, input, RES_SIZE: ALU result, sampled on vld && rdy.
REQ-013 Ports busy and done (output, 1) SHALL be status flags.
REQ-014 Port count, output, OP_SIZE+2*DATA_SIZE+1: number of accepted vectors.
REQ-015 Port signature, output, RES_SIZE: result signature.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE; busy=1 only in RUN, done=1 only in DONE.
REQ-017 start in IDLE or DONE SHALL clear op/src_data/dest_data/ext/count/signature, latch misc_cfg, and enter RUN; vld=1 with vector (0,0,0) on the next cycle.
REQ-018 start in RUN SHALL be ignored.
REQ-019 While vld=1 && rdy=0 the vector outputs SHALL hold stable.
REQ-020 On vld && rdy: signature <= {signature[RES_SIZE-2:0], signature[RES_SIZE-1]} ^ res; count <= count+1; vector advances next cycle with vld kept at 1 (back-to-back accepts allowed).
REQ-021 Advance order: src_data increments innermost; at 2^DATA_SIZE-1 it wraps to 0 and dest_data increments; dest_data wrap increments op; op never exceeds OP_LAST.
REQ-022 Accept of the final vector (src and dest at max, op=OP_LAST, final ext pass) SHALL enter DONE: vld=0, done=1 next cycle; count and signature hold until next start or rst.
REQ-023 Total vectors per sweep SHALL be (OP_LAST+1)*2^(2*DATA_SIZE), times 2 when ALU_SWEEP_EXT_EN is defined; defaults give 7168 (14336).
REQ-024 vld SHALL be 0 in IDLE and DONE; rdy is ignored there.

Reset
REQ-025 rst SHALL force IDLE and zero op, src_data, dest_data, ext, misc, vld, busy, done, count, signature on the next edge, including mid-sweep; rst takes priority over start.

Configuration
REQ-026 Macro ALU_SWEEP_EXT_EN defined: ext SHALL be swept as the outermost dimension (full op/dest/src sweep with ext=0, then again with ext=1; done after the final ext=1 vector).
REQ-027 ALU_SWEEP_EXT_EN undefined: ext SHALL be constant 0 and only one pass occurs.

Verification
REQ-028 DATA_SIZE=2, OP_LAST=1, rdy=1, res=0, start pulse -> exactly 32 vld cycles, order (op,dest,src)=(0,0,0),(0,0,1)..(0,0,3),(0,1,0)..(1,3,3); done=1, count=32, signature=0.
REQ-029 Same config, res constant 1 -> signature after 1,2,3 accepts = 1,3,7; after 16 accepts = 16'hFFFF.
REQ-030 rdy held 0 for 5 cycles at vector (0,2,1) -> outputs unchanged for 5 cycles, count unchanged; rdy=1 -> (0,2,2) next cycle.
REQ-031 rst asserted at count=10 -> next cycle vld=0, busy=0, count=0, signature=0; start then -> sweep restarts at (0,0,0).
REQ-032 start pulsed mid-sweep at count=5 -> ignored, sweep completes with count=32; start in DONE -> fresh sweep, count restarts from 0.
REQ-033 ALU_SWEEP_EXT_EN defined, DATA_SIZE=2, OP_LAST=1 -> 64 vectors, ext=0 for first 32 and ext=1 for last 32, count=64 at done.
